// File: rtl/symml_vec_gen.sv
// symml_vec_gen: enumerates every N-bit vector of a requested Hamming
// weight over a valid/ready stream, tagging each beat with the band flag.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start_i, weight_i run request and target weight (sampled in IDLE)
//   abort_i           abandon a running enumeration
//   vec_o, valid_o    current vector and its qualifier
//   ready_i           sink accepts the beat on valid_o & ready_i
//   last_o            final vector of the run
//   band_o            BAND_LO <= weight <= BAND_HI
//   beat_o            zero-based beat index
//   busy_o, done_o    not idle / end-of-run pulse
//   err_o             last start requested weight > N
module symml_vec_gen #(
    parameter int N       = 9,
    parameter int BAND_LO = 3,
    parameter int BAND_HI = 6,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [4:0]    weight_i,
    input  logic          abort_i,
    output logic [N-1:0]  vec_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          last_o,
    output logic          band_o,
    output logic [CW-1:0] beat_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EMIT = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]    state_q;
    logic [N-1:0]  vec_q;
    logic [N-1:0]  max_q;
    logic          valid_q;
    logic          last_q;
    logic          band_q;
    logic [CW-1:0] beat_q;
    logic          done_q;
    logic          err_q;

    logic          w_ok;
    logic          band_n;
    logic [N-1:0]  first_v;
    logic [N-1:0]  max_v;

    always_comb begin
        w_ok    = int'(weight_i) <= N;
        band_n  = (int'(weight_i) >= BAND_LO) &&
                  (int'(weight_i) <= BAND_HI);
        first_v = ~({N{1'b1}} << weight_i);
        // top `weight` bits set: the last vector of the run
        max_v   = ~({N{1'b1}} >> weight_i);
    end

    logic [N:0]   gx;
    logic [N:0]   gc;
    logic [N:0]   gr;
    logic [4:0]   tz;
    logic [N-1:0] next_v;
    logic         next_last;

    // next larger vector with the same popcount (Gosper)
    always_comb begin
        gx = {1'b0, vec_q};
        gc = gx & (~gx + 1'b1);
        gr = gx + gc;
        tz = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_q[i]) tz = 5'(i);
        end
        next_v    = N'(gr | ((gx ^ gr) >> (tz + 5'd2)));
        next_last = (next_v == max_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            max_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            band_q  <= 1'b0;
            beat_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (w_ok) begin
                            state_q <= EMIT;
                            vec_q   <= first_v;
                            max_q   <= max_v;
                            beat_q  <= '0;
                            band_q  <= band_n;
                            last_q  <= (first_v == max_v);
                            valid_q <= 1'b1;
                            err_q   <= 1'b0;
                        end else begin
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    // abort wins over a same-cycle handshake
                    if (abort_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end else if (ready_i) begin
                        if (last_q) begin
                            state_q <= FIN;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            vec_q  <= next_v;
                            beat_q <= beat_q + 1'b1;
                            last_q <= next_last;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign vec_o   = vec_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign band_o  = band_q;
    assign beat_o  = beat_q;
    assign busy_o  = (state_q != IDLE);
    assign done_o  = done_q;
    assign err_o   = err_q;

endmodule

// File: doc/symml_vec_gen.md
Name: symml_vec_gen

Overview:
- Stimulus-side counterpart to the 9-input symmetric (9symml-class) recogniser used in the power-aware synthesis benchmark flow.
- The recogniser maps a 9-bit vector to a 1-bit "weight in band" flag. This block runs the other direction: given a target Hamming weight, it enumerates every N-bit vector of that weight over a valid/ready stream.
- Each beat carries the golden band flag, so a downstream checker or power-activity harness can compare it against the recogniser output.

Parameters:
- N, 9, vector width; legal range 2..16.
- BAND_LO, 3, lowest weight for which band_o = 1.
- BAND_HI, 6, highest weight for which band_o = 1; BAND_LO <= BAND_HI <= N.
- CW, 16, width of beat counter beat_o; must hold C(N, N/2).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle request; sampled only in IDLE.
- weight_i  in  5  target Hamming weight; sampled with start_i.
- abort_i  in  1  synchronous abort of a running enumeration.
- vec_o  out  N  current vector.
- valid_o  out  1  vec_o, band_o, last_o and beat_o are valid.
- ready_i  in  1  sink accepts the beat when valid_o & ready_i.
- last_o  out  1  final vector of the enumeration; qualified by valid_o.
- band_o  out  1  1 iff BAND_LO <= weight <= BAND_HI; constant for a run.
- beat_o  out  CW  zero-based index of the current beat.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse after the last beat is accepted, or after an error.
- err_o  out  1  sticky: weight_i > N on the most recent start; cleared by the next accepted start.

Behaviour:
- Reset (async, rst_n = 0): state = IDLE. vec_o, valid_o, last_o, band_o, beat_o, busy_o, done_o and err_o are all 0.
- States are IDLE, EMIT and FIN.
- IDLE:
  - start_i = 1 with weight_i <= N: latch the weight, vec_o = 2^weight - 1, beat_o = 0, band_o computed. Enter EMIT next cycle; valid_o rises one cycle after start.
  - start_i = 1 with weight_i > N: err_o = 1, done_o pulses the next cycle, no beats are emitted, stay in IDLE.
  - start_i is ignored in EMIT and FIN.
- EMIT:
  - valid_o = 1. Outputs are held stable while valid_o & !ready_i (AXI-style; valid never drops without a handshake except on abort or reset).
  - last_o = 1 iff vec_o equals the maximal vector, i.e. the top `weight` bits set.
  - Handshake on a non-last beat: vec_o advances to the next larger vector of the same weight, beat_o increments, and the next beat is presented the following cycle with no bubble.
  - Next-vector rule (Gosper): c = x & -x; r = x + c; next = r | ((x ^ r) >> (tz(x) + 2)), where tz = trailing-zero count. Arithmetic is performed in N+1 bits and the result is truncated to N; overflow cannot occur on a non-last beat.
  - Handshake on the last beat: go to FIN.
- FIN: valid_o = 0, done_o = 1 for exactly one cycle, then IDLE.
- Weight 0: a single beat with vec_o = 0, last_o = 1, beat_o = 0.
- Weight N: a single beat with vec_o all ones, last_o = 1.
- Throughput: one vector per cycle when ready_i is held high. Total beats = C(N, weight).
- abort_i in EMIT:
  - Takes priority over the handshake in the same cycle; the beat is not counted as accepted by the generator.
  - Next cycle: IDLE, valid_o = 0, no done_o pulse.
  - abort_i in IDLE or FIN has no effect.
- Reset asserted mid-run: immediate return to reset values; no done_o.
- Outputs are registered; no combinational path from ready_i or start_i to any output.

Test Plan:
- Reset checks: assert rst_n = 0 mid-EMIT at an arbitrary phase -> all outputs 0 immediately, IDLE after release; start weight 3 afterwards -> normal run.
- Band-edge run, weight 3, N = 9, ready_i = 1:
  - first beat vec 0x007, second 0x00B, third 0x00D, ...
  - last beat vec 0x1C0 with last_o = 1 and beat_o = 83 (84 beats total);
  - band_o = 1 throughout; done_o pulses one cycle after the last handshake.
- Out-of-band and degenerate weights:
  - weight 2 -> 36 beats, band_o = 0;
  - weight 7 -> 36 beats, band_o = 0;
  - weight 0 -> single beat 0x000 with last_o = 1;
  - weight 9 -> single beat 0x1FF with last_o = 1.
- Backpressure and full coverage, weight 4:
  - ready_i random with about 50 % duty -> vec_o stable while stalled, no beat lost or duplicated;
  - 126 beats, all distinct, each popcount 4, strictly ascending;
  - cross-check: the 9symml recogniser output equals band_o on every beat.
- Error and ignored requests:
  - weight_i = 12 -> no valid_o, err_o = 1, done_o pulse;
  - next start with weight 5 -> err_o clears, 126 beats;
  - start_i pulsed during EMIT -> ignored.
- Abort: abort_i at beat 10 of weight 5 while ready_i = 1 -> valid_o low next cycle, busy_o = 0, no done_o; a new start restarts at vec 0x01F, beat_o = 0.
